// File: rtl/des_pkg.sv
// des_pkg: shared types, tables and helpers for the DES round datapath.
//   half_t   : 32-bit Feistel half, DES bit 1 at [31]
//   subkey_t : 48-bit round subkey, DES bit 1 at [47]
//   blk_t    : {l, r} pair carried through the stage registers
//   E_TABLE / P_TABLE : FIPS 46-3 tables, 1-based bit numbering
//   SBOX_ROWS : S-box rows, one 64-bit word per row, column 0 in the top nibble
//   expand()    : E expansion 32 -> 48
//   permute_p() : P permutation 32 -> 32
package des_pkg;

    typedef logic [31:0] half_t;
    typedef logic [47:0] subkey_t;

    typedef struct packed {
        half_t l;
        half_t r;
    } blk_t;

    localparam int E_TABLE [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // [box][row] -> 16 nibbles, column 0 in [63:60]
    localparam logic [63:0] SBOX_ROWS [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    // DES bit n of a 32-bit half lives at [32-n]; of the 48-bit word at [48-n].
    function automatic subkey_t expand(input half_t r);
        subkey_t    e;
        logic [4:0] src;
        e = '0;
        for (int i = 0; i < 48; i++) begin
            src = 5'(32 - E_TABLE[i]);
            e[6'(47 - i)] = r[src];
        end
        return e;
    endfunction

    function automatic half_t permute_p(input half_t s);
        half_t      p;
        logic [4:0] src;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            src = 5'(32 - P_TABLE[i]);
            p[5'(31 - i)] = s[src];
        end
        return p;
    endfunction

endpackage

// File: rtl/des_f.sv
// des_f: combinational DES f-function, f(R,K) = P(S1..S8(E(R) ^ K)).
//   r_i : right half R(i-1)
//   k_i : round subkey K(i)
//   f_o : f-function result
module des_f
    import des_pkg::*;
(
    input  half_t   r_i,
    input  subkey_t k_i,
    output half_t   f_o
);

    subkey_t x;
    half_t   s_layer;

    assign x = expand(r_i) ^ k_i;

    // group g (S(g+1)) takes x[47-6g -: 6] and lands in s_layer[31-4g -: 4]
    for (genvar g = 0; g < 8; g++) begin : g_sbox
        des_sbox #(.IDX(g)) u_sbox (
            .six_i (x[47-6*g -: 6]),
            .nib_o (s_layer[31-4*g -: 4])
        );
    end

    assign f_o = permute_p(s_layer);

endmodule

// File: rtl/des_sbox.sv
// des_sbox: one DES S-box lookup (6 -> 4 bits), box chosen by IDX (0 = S1).
//   six_i : 6-bit group b5..b0; row = {b5,b0}, column = b4..b1
//   nib_o : 4-bit S-box output
module des_sbox
    import des_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic [5:0] six_i,
    output logic [3:0] nib_o
);

    localparam logic [2:0] SEL = 3'(IDX);

    logic [1:0]  row;
    logic [3:0]  col;
    logic [63:0] row_bits;
    logic [5:0]  sh;

    assign row      = {six_i[5], six_i[0]};
    assign col      = six_i[4:1];
    assign row_bits = SBOX_ROWS[SEL][row];
    // column 0 sits in the top nibble, so the shift is (15-col)*4
    assign sh       = {~col, 2'b00};
    assign nib_o    = row_bits[sh +: 4];

endmodule

// File: rtl/des_round_stage.sv
// des_round_stage: one registered DES Feistel round with valid/ready handshake.
//   clk, n_rst           : clock, async active-low reset
//   in_valid/in_ready    : input handshake
//   in_l, in_r, in_key   : L(i-1), R(i-1), K(i)
//   in_last              : final round, no half swap
//   in_tag               : sideband carried to out_tag
//   out_valid/out_ready  : output handshake
//   out_l, out_r, out_tag: L(i), R(i), tag
// Build option DES_ROUND_SKID_EN: adds a one-entry skid buffer behind the
// output register and makes in_ready a flop (no path from out_ready).
module des_round_stage
    import des_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_l,
    input  logic [31:0]      in_r,
    input  logic [47:0]      in_key,
    input  logic             in_last,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_l,
    output logic [31:0]      out_r,
    output logic [TAG_W-1:0] out_tag
);

    half_t f;
    blk_t  res;
    logic  in_xfer, out_xfer;

    des_f u_f (
        .r_i (in_r),
        .k_i (in_key),
        .f_o (f)
    );

    // last round keeps the halves in place
    always_comb begin
        res = '0;
        if (in_last) begin
            res.l = in_l ^ f;
            res.r = in_r;
        end else begin
            res.l = in_r;
            res.r = in_l ^ f;
        end
    end

    logic             vld_q, vld_d;
    blk_t             blk_q, blk_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = vld_q & out_ready;

`ifdef DES_ROUND_SKID_EN
    logic             skid_vld_q, skid_vld_d;
    blk_t             skid_blk_q, skid_blk_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             rdy_q, rdy_d;

    assign in_ready = rdy_q;

    always_comb begin
        vld_d      = vld_q;
        blk_d      = blk_q;
        tag_d      = tag_q;
        skid_vld_d = skid_vld_q;
        skid_blk_d = skid_blk_q;
        skid_tag_d = skid_tag_q;
        if (skid_vld_q) begin
            // in_ready is low here, so only a drain can happen
            if (out_xfer) begin
                blk_d      = skid_blk_q;
                tag_d      = skid_tag_q;
                skid_vld_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (vld_q && !out_ready) begin
                skid_vld_d = 1'b1;
                skid_blk_d = res;
                skid_tag_d = in_tag;
            end else begin
                vld_d = 1'b1;
                blk_d = res;
                tag_d = in_tag;
            end
        end else if (out_xfer) begin
            vld_d = 1'b0;
        end
        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q      <= 1'b0;
            blk_q      <= '0;
            tag_q      <= '0;
            skid_vld_q <= 1'b0;
            skid_blk_q <= '0;
            skid_tag_q <= '0;
            rdy_q      <= 1'b1;
        end else begin
            vld_q      <= vld_d;
            blk_q      <= blk_d;
            tag_q      <= tag_d;
            skid_vld_q <= skid_vld_d;
            skid_blk_q <= skid_blk_d;
            skid_tag_q <= skid_tag_d;
            rdy_q      <= rdy_d;
        end
    end
`else
    assign in_ready = !vld_q | out_ready;

    always_comb begin
        vld_d = vld_q;
        blk_d = blk_q;
        tag_d = tag_q;
        if (in_xfer) begin
            vld_d = 1'b1;
            blk_d = res;
            tag_d = in_tag;
        end else if (out_xfer) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q <= 1'b0;
            blk_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            blk_q <= blk_d;
            tag_q <= tag_d;
        end
    end
`endif

    assign out_valid = vld_q;
    assign out_l     = blk_q.l;
    assign out_r     = blk_q.r;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_des_round_stage.sv
module tb_des_round_stage;

    localparam int TAG_W = 4;
`ifdef DES_ROUND_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_l = '0;
    logic [31:0]      in_r = '0;
    logic [47:0]      in_key = '0;
    logic             in_last = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_l, out_r;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;
    int n_in = 0;
    int n_out = 0;

    typedef struct {
        logic [31:0]      l;
        logic [31:0]      r;
        logic [TAG_W-1:0] tag;
    } beat_t;
    beat_t q[$];

    des_round_stage #(.TAG_W(TAG_W)) dut (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_l(in_l), .in_r(in_r), .in_key(in_key), .in_last(in_last), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_l(out_l), .out_r(out_r), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (DES bit numbering, 1-based) ----------
    localparam int ET [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    // DES bit n (1 = MSB) of a width-bit value
    function automatic int desbit(input logic [63:0] v, input int width, input int n);
        return int'((v >> (width - n)) & 64'd1);
    endfunction

    function automatic logic [31:0] m_slayer(input logic [31:0] r, input logic [47:0] k);
        logic [31:0] s;
        int b[6];
        int row, col, v;
        s = '0;
        for (int g = 0; g < 8; g++) begin
            for (int j = 0; j < 6; j++)
                b[j] = desbit(64'(r), 32, ET[6*g+j]) ^ desbit(64'(k), 48, 6*g+j+1);
            row = b[0]*2 + b[5];
            col = b[1]*8 + b[2]*4 + b[3]*2 + b[4];
            v   = SB[g][row*16 + col];
            s   = (s << 4) | 32'(v);
        end
        return s;
    endfunction

    function automatic logic [31:0] m_p(input logic [31:0] s);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) p = (p << 1) | 32'(desbit(64'(s), 32, PT[i]));
        return p;
    endfunction

    function automatic beat_t m_beat(input logic [31:0] l, input logic [31:0] r,
                                     input logic [47:0] k, input logic last,
                                     input logic [TAG_W-1:0] tag);
        beat_t       b;
        logic [31:0] f;
        f = m_p(m_slayer(r, k));
        b.tag = tag;
        if (last) begin b.l = l ^ f; b.r = r;     end
        else      begin b.l = r;     b.r = l ^ f; end
        return b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle scoreboard compare -------------------------
    initial begin : monitor
        logic  ix, ox;
        beat_t nb;
        forever begin
            @(negedge clk); #4;
            ix = n_rst & in_valid & in_ready;
            ox = n_rst & out_valid & out_ready;
            nb = m_beat(in_l, in_r, in_key, in_last, in_tag);
            @(posedge clk); #1;
            if (!n_rst) begin
                q.delete();
            end else begin
                if (ox) begin
                    n_out++;
                    if (q.size() > 0) void'(q.pop_front());
                end
                if (ix) begin
                    n_in++;
                    q.push_back(nb);
                end
                chk("sb_out_valid", 64'(out_valid), 64'(q.size() > 0));
                if (CAP == 1) chk("sb_in_ready", 64'(in_ready), 64'((q.size() == 0) | out_ready));
                else          chk("sb_in_ready", 64'(in_ready), 64'(q.size() < CAP));
                if (q.size() > 0) begin
                    chk("sb_out_l", 64'(out_l), 64'(q[0].l));
                    chk("sb_out_r", 64'(out_r), 64'(q[0].r));
                    chk("sb_out_tag", 64'(out_tag), 64'(q[0].tag));
                end
            end
        end
    end

    // ---------------- stimulus --------------------------------------------
    task automatic drive(input logic v, input logic [31:0] l, input logic [31:0] r,
                         input logic [47:0] k, input logic last,
                         input logic [TAG_W-1:0] tag, input logic ordy);
        @(negedge clk);
        in_valid = v; in_l = l; in_r = r; in_key = k; in_last = last; in_tag = tag;
        out_ready = ordy;
    endtask

    function automatic logic [31:0] dl(input int i); return 32'h9E3779B9 * 32'(i + 1); endfunction
    function automatic logic [31:0] dr(input int i); return 32'h7F4A7C15 ^ (32'h01010101 * 32'(i)); endfunction
    function automatic logic [47:0] dk(input int i); return 48'h1B02EFFC7072 + 48'h0000_1234_5678 * 48'(i); endfunction

    initial begin : stim
        int sent, out0;

        // the model itself against published numbers
        chk("model_slayer_kv", 64'(m_slayer(32'hF0AAF0AA, 48'h1B02EFFC7072)), 64'h5C82B597);
        chk("model_f_kv", 64'(m_p(m_slayer(32'hF0AAF0AA, 48'h1B02EFFC7072))), 64'h234AA9BB);
        chk("model_slayer_zero", 64'(m_slayer(32'h0, 48'h0)), 64'hEFA72C4D);

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_l", 64'(out_l), 64'd0);
        chk("rst_out_r", 64'(out_r), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        n_rst = 1'b1;

        // known vector, normal round then last round
        drive(1, 32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 0, 4'd1, 1);
        #1 chk("kv_s_layer", 64'(dut.u_f.s_layer), 64'h5C82B597);
        @(posedge clk); #2;
        chk("kv_valid", 64'(out_valid), 64'd1);
        chk("kv_out_l", 64'(out_l), 64'hF0AAF0AA);
        chk("kv_out_r", 64'(out_r), 64'hEF4A6544);
        drive(1, 32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1, 4'd2, 1);
        @(posedge clk); #2;
        chk("kv_last_out_l", 64'(out_l), 64'hEF4A6544);
        chk("kv_last_out_r", 64'(out_r), 64'hF0AAF0AA);
        chk("kv_last_tag", 64'(out_tag), 64'd2);

        // zero S-layer input
        drive(1, 32'h12345678, 32'h0, 48'h0, 0, 4'd3, 1);
        #1 chk("zero_s_layer", 64'(dut.u_f.s_layer), 64'hEFA72C4D);
        @(posedge clk); #2;
        chk("zero_out_r", 64'(out_r), 64'(m_p(32'hEFA72C4D) ^ 32'h12345678));
        chk("zero_out_l", 64'(out_l), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #2;
        chk("idle_valid", 64'(out_valid), 64'd0);

        // backpressure: 5 stalled cycles offering 3 beats
        sent = 0;
        out0 = n_out;
        for (int c = 0; c < 5; c++) begin
            drive(1, dl(sent), dr(sent), dk(sent), 1'(sent & 1), 4'(4 + sent), 0);
            #4 if (in_valid && in_ready) sent++;
        end
        chk("bp_held", 64'(sent), 64'(CAP));
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        for (int c = 0; c < 10 && sent < 3; c++) begin
            drive(1, dl(sent), dr(sent), dk(sent), 1'(sent & 1), 4'(4 + sent), 1);
            #4 if (in_valid && in_ready) sent++;
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #2;
            if (q.size() == 0 && !out_valid) break;
        end
        chk("bp_all_accepted", 64'(sent), 64'd3);
        chk("bp_all_emerged", 64'(n_out - out0), 64'd3);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // full throughput, tags 0..15
        for (int i = 0; i < 16; i++) begin
            drive(1, dl(i), dr(i), dk(i), 0, 4'(i), 1);
            @(posedge clk); #2;
            chk("tput_valid", 64'(out_valid), 64'd1);
            chk("tput_tag", 64'(out_tag), 64'(i));
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #2;
        chk("tput_end_valid", 64'(out_valid), 64'd0);

        // reset while stalled
        drive(1, dl(20), dr(20), dk(20), 0, 4'd7, 0);
        drive(1, dl(21), dr(21), dk(21), 0, 4'd8, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("stall_before_rst", 64'(out_valid), 64'd1);
        #1 n_rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_l", 64'(out_l), 64'd0);
        chk("mid_rst_out_r", 64'(out_r), 64'd0);
        chk("mid_rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        drive(1, dl(22), dr(22), dk(22), 1, 4'd9, 1);
        @(posedge clk); #2;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_tag", 64'(out_tag), 64'd9);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #2;
        chk("post_rst_alone", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        chk("end_balance", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout, want $finish before %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
